ahb_lite_master: RTL and testbench

Single-outstanding AHB-Lite initiator converting a simple valid/ready request port into AHB-Lite SINGLE transfers. It sits between a local requester (DMA engine, debug bridge, test sequencer) and the AHB interconnect, and drives peripheral slaves such as the UART and GPIO AHB wrappers. It handles slave wait states and ERROR responses, and returns read data and status on a one-cycle response strobe.

---
 rtl/ahb_lite_master.sv | 164 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready request in, SINGLE transfers out.
// Optional data-phase watchdog is enabled with `define AHB_LITE_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int unsigned AW  = 32,
    parameter int unsigned TMO = 255
) (
    input  logic          hclk,
    input  logic          hresetn,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [2:0]    req_size,
    input  logic [31:0]   req_wd,

    output logic          rsp_valid,
    output logic [31:0]   rsp_rd,
    output logic          rsp_err,

    output logic [AW-1:0] haddr,
    output logic          hwrite,
    output logic [1:0]    htrans,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [31:0]   hwdata,
    input  logic [31:0]   hrdata,
    input  logic          hready,
    input  logic [1:0]    hresp
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [2:0]    size_q;
    logic [31:0]   wd_q;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rd_q, rsp_rd_d;
    logic          rsp_err_q, rsp_err_d;
    logic          accept;
    logic [2:0]    size_clamped;

    assign accept       = req_valid && (state_q == StIdle);
    // Sizes above a word are not supported by the slaves; clamp to word.
    assign size_clamped = (req_size > 3'd2) ? 3'd2 : req_size;

`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_hit;
    logic        unused_hresp;

    assign unused_hresp = hresp[1];
    assign tmo_hit      = (32'(cnt_q) + 32'd1) == TMO;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_in;

    assign unused_in = ^{hresp[1], TMO[0]};
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (hready) begin
                    state_d = StData;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StData: begin
                if (hready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = we_q ? 32'd0 : hrdata;
                    rsp_err_d   = hresp[0];
                end
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Abandon the stuck transfer; a late slave completion is ignored.
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = 32'd0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            size_q <= '0;
            wd_q   <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            we_q   <= req_we;
            size_q <= size_clamped;
            wd_q   <= req_wd;
        end
    end

    // Bus outputs come from registers or the state only; no hready/hrdata feedthrough.
    always_comb begin
        req_ready = (state_q == StIdle);
        htrans    = (state_q == StAddr) ? TransNonseq : TransIdle;
        haddr     = addr_q;
        hwrite    = we_q;
        hsize     = size_q;
        hburst    = 3'b000;
        hwdata    = wd_q;
        rsp_valid = rsp_valid_q;
        rsp_rd    = rsp_rd_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master (default build, timeout disabled).
module tb_ahb_lite_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_wd;
    logic        rsp_valid;
    logic [31:0] rsp_rd;
    logic        rsp_err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_master #(.AW(32), .TMO(255)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_wd    (req_wd),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_err   (rsp_err),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".rsp_rd"},    rsp_rd,         32'd0);
        check({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, ".haddr"},     haddr,          32'd0);
        check({tag, ".hwrite"},    32'(hwrite),    32'd0);
        check({tag, ".htrans"},    32'(htrans),    32'd0);
        check({tag, ".hsize"},     32'(hsize),     32'd0);
        check({tag, ".hwdata"},    hwdata,         32'd0);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wd    = wd;
    endtask

    initial begin
        hresetn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_size  = '0;
        req_wd    = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 2'b00;
        #12;
        check_reset_values("reset");
        check("reset.hburst", 32'(hburst), 32'd0);
        hresetn = 1'b1;
        tick();

        // Zero-wait write.
        issue(1'b1, 32'h4, 3'd2, 32'hDEADBEEF);
        check("wr.req_ready_idle", 32'(req_ready), 32'd1);
        tick();                                   // edge 0: accept
        req_valid = 1'b0;
        check("wr.htrans_nonseq", 32'(htrans), 32'h2);
        check("wr.haddr", haddr, 32'h4);
        check("wr.hwrite", 32'(hwrite), 32'd1);
        check("wr.hsize", 32'(hsize), 32'd2);
        check("wr.req_ready_busy", 32'(req_ready), 32'd0);
        tick();                                   // edge 1: data phase
        check("wr.htrans_data", 32'(htrans), 32'd0);
        check("wr.hwdata", hwdata, 32'hDEADBEEF);
        check("wr.no_early_rsp", 32'(rsp_valid), 32'd0);
        tick();                                   // edge 2: completion
        check("wr.rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr.rsp_err", 32'(rsp_err), 32'd0);
        check("wr.rsp_rd", rsp_rd, 32'd0);
        tick();
        check("wr.rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // Read with two data-phase wait states; illegal size clamps to word.
        issue(1'b0, 32'h10, 3'd5, 32'h0);
        tick();                                   // edge 0
        req_valid = 1'b0;
        check("rd.hsize_clamped", 32'(hsize), 32'd2);
        check("rd.hwrite", 32'(hwrite), 32'd0);
        tick();                                   // edge 1: DATA
        hready = 1'b0;
        hrdata = 32'hBAD0BAD0;
        tick();                                   // edge 2: wait
        check("rd.wait1_no_rsp", 32'(rsp_valid), 32'd0);
        tick();                                   // edge 3: wait
        check("rd.wait2_no_rsp", 32'(rsp_valid), 32'd0);
        hready = 1'b1;
        hrdata = 32'h12345678;
        tick();                                   // edge 4: completion
        hrdata = 32'h0;
        check("rd.rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd.rsp_rd", rsp_rd, 32'h12345678);
        check("rd.rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("rd.rsp_rd_held", rsp_rd, 32'h12345678);

        // Address-phase stall for three cycles.
        hready = 1'b0;
        issue(1'b1, 32'h20, 3'd1, 32'h0000A5A5);
        tick();                                   // edge 0
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d.htrans", i), 32'(htrans), 32'h2);
            check($sformatf("stall%0d.haddr", i), haddr, 32'h20);
            check($sformatf("stall%0d.hwrite", i), 32'(hwrite), 32'd1);
            check($sformatf("stall%0d.hsize", i), 32'(hsize), 32'd1);
            if (i < 3) tick();
        end
        hready = 1'b1;
        tick();                                   // edge 4: DATA
        check("stall.htrans_data", 32'(htrans), 32'd0);
        check("stall.hwdata", hwdata, 32'h0000A5A5);
        check("stall.no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
        tick();

        // Two-cycle ERROR response.
        issue(1'b0, 32'h30, 3'd0, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();                                   // DATA
        hready = 1'b0;
        hresp  = 2'b01;
        check("err.htrans_c1", 32'(htrans), 32'd0);
        tick();
        check("err.htrans_c2", 32'(htrans), 32'd0);
        check("err.no_rsp", 32'(rsp_valid), 32'd0);
        hready = 1'b1;
        tick();
        hresp = 2'b00;
        check("err.rsp_valid", 32'(rsp_valid), 32'd1);
        check("err.rsp_err", 32'(rsp_err), 32'd1);
        check("err.htrans_after", 32'(htrans), 32'd0);
        tick();
        check("err.rsp_err_held", 32'(rsp_err), 32'd1);

        // Back-to-back read then write, then reset mid-DATA of the write.
        issue(1'b0, 32'h40, 3'd2, 32'h0);
        hrdata = 32'hCAFEF00D;
        tick();                                   // edge 0: first accept
        issue(1'b1, 32'h44, 3'd2, 32'h55AA55AA);
        check("b2b.busy", 32'(req_ready), 32'd0);
        tick();                                   // edge 1
        check("b2b.addr_held", haddr, 32'h40);
        tick();                                   // edge 2: first response
        check("b2b.rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b.rsp_rd", rsp_rd, 32'hCAFEF00D);
        check("b2b.ready_with_rsp", 32'(req_ready), 32'd1);
        tick();                                   // edge 3: second accept
        req_valid = 1'b0;
        check("b2b.htrans2", 32'(htrans), 32'h2);
        check("b2b.haddr2", haddr, 32'h44);
        check("b2b.hwrite2", 32'(hwrite), 32'd1);
        tick();                                   // edge 4: DATA
        hready = 1'b0;
        check("b2b.hwdata2", hwdata, 32'h55AA55AA);
        tick();
        #2;
        hresetn = 1'b0;
        #1;
        check_reset_values("midrst");
        hready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst.no_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        #3;
        hresetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("post.no_rsp%0d", i), 32'(rsp_valid), 32'd0);
            check($sformatf("post.htrans%0d", i), 32'(htrans), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
